// File: rtl/battleship_pkg.sv
// Shared Keyboard Battleship definitions: screen codes, game states, player IDs.
package battleship_pkg;

  localparam int unsigned SCREEN_W = 6;

  // One-hot codes consumed by the display screen mux
  localparam logic [SCREEN_W-1:0] SCR_START = 6'd1;
  localparam logic [SCREEN_W-1:0] SCR_HIT   = 6'd2;
  localparam logic [SCREEN_W-1:0] SCR_MISS  = 6'd4;
  localparam logic [SCREEN_W-1:0] SCR_P1WIN = 6'd8;
  localparam logic [SCREEN_W-1:0] SCR_P2WIN = 6'd16;
  localparam logic [SCREEN_W-1:0] SCR_PLAY  = 6'd32;

  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_AIM    = 3'd1,
    S_LOOKUP = 3'd2,
    S_SHOW   = 3'd3,
    S_WIN    = 3'd4
  } state_t;

  // Win screen for the player who just fired
  function automatic logic [SCREEN_W-1:0] win_screen(input logic shooter);
    return (shooter == P2) ? SCR_P2WIN : SCR_P1WIN;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Result-screen hold counter: cleared by load, counts 0..HOLD_CYCLES-1 while enabled, sticks at terminal count.
module hold_timer #(
  parameter int unsigned HOLD_CYCLES = 100_000_000,
  parameter int unsigned HOLD_W      = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic done_c
);

  localparam logic [HOLD_W-1:0] LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] count;

  assign done_c = (count == LAST);

  // Counter register; load has priority so entry to the hold always starts at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && !done_c) begin
      count <= count + HOLD_W'(1);
    end
  end

endmodule

// File: rtl/turn_sequencer.sv
// Battleship game-flow controller: start, alternating turns, board lookup, result hold, win screen.
module turn_sequencer
  import battleship_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 100_000_000,
  parameter int unsigned SHIP_CELLS  = 17,
  parameter int unsigned HOLD_W      = 27,
  parameter int unsigned SCORE_W     = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_pulse,
  input  logic                fire_pulse,
  input  logic                lookup_ack,
  input  logic                lookup_hit,
  output logic                lookup_req,
  output logic                lookup_board,
  output logic                turn,
  output logic [SCREEN_W-1:0] screen,
  output logic [SCORE_W-1:0]  p1_score,
  output logic [SCORE_W-1:0]  p2_score,
  output logic                game_over
);

  localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(SHIP_CELLS);

  state_t state_q, state_d;

  logic                lookup_req_d;
  logic                turn_d;
  logic [SCREEN_W-1:0] screen_d;
  logic [SCORE_W-1:0]  p1_score_d, p2_score_d;
  logic                game_over_d;

  logic                hold_load_c, hold_en_c, hold_done_c;
  logic [SCORE_W-1:0]  shooter_score_c;
  logic                shooter_won_c;

  assign hold_load_c     = (state_q == S_LOOKUP) && lookup_ack;
  assign hold_en_c       = (state_q == S_SHOW);
  assign shooter_score_c = (turn == P2) ? p2_score : p1_score;
  assign shooter_won_c   = (shooter_score_c == WIN_SCORE);

  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .HOLD_W      (HOLD_W)
  ) u_hold_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (hold_load_c),
    .en     (hold_en_c),
    .done_c (hold_done_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start_pulse) state_d = S_AIM;
      S_AIM:    if (fire_pulse)  state_d = S_LOOKUP;
      S_LOOKUP: if (lookup_ack)  state_d = S_SHOW;
      S_SHOW:   if (hold_done_c) state_d = shooter_won_c ? S_WIN : S_AIM;
      S_WIN:    if (start_pulse) state_d = S_AIM;
      default:                   state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    lookup_req_d = lookup_req;
    turn_d       = turn;
    screen_d     = screen;
    p1_score_d   = p1_score;
    p2_score_d   = p2_score;
    game_over_d  = game_over;
    unique case (state_q)
      S_IDLE, S_WIN: begin
        if (start_pulse) begin
          turn_d      = P1;
          p1_score_d  = '0;
          p2_score_d  = '0;
          game_over_d = 1'b0;
          screen_d    = SCR_PLAY;
        end
      end
      S_AIM: begin
        if (fire_pulse) lookup_req_d = 1'b1;
      end
      S_LOOKUP: begin
        if (lookup_ack) begin
          lookup_req_d = 1'b0;
          if (lookup_hit) begin
            screen_d = SCR_HIT;
            // Saturating increment of the shooter's tally
            if (shooter_score_c < WIN_SCORE) begin
              if (turn == P2) p2_score_d = p2_score + SCORE_W'(1);
              else            p1_score_d = p1_score + SCORE_W'(1);
            end
          end else begin
            screen_d = SCR_MISS;
          end
        end
      end
      S_SHOW: begin
        if (hold_done_c) begin
          if (shooter_won_c) begin
            screen_d    = win_screen(turn);
            game_over_d = 1'b1;
          end else begin
            turn_d   = ~turn;
            screen_d = SCR_PLAY;
          end
        end
      end
      default: begin
        lookup_req_d = 1'b0;
        screen_d     = SCR_START;
      end
    endcase
  end

  // Output registers; the queried board always tracks the opponent of the next shooter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lookup_req   <= 1'b0;
      lookup_board <= ~P1;
      turn         <= P1;
      screen       <= SCR_START;
      p1_score     <= '0;
      p2_score     <= '0;
      game_over    <= 1'b0;
    end else begin
      lookup_req   <= lookup_req_d;
      lookup_board <= ~turn_d;
      turn         <= turn_d;
      screen       <= screen_d;
      p1_score     <= p1_score_d;
      p2_score     <= p2_score_d;
      game_over    <= game_over_d;
    end
  end

endmodule

// File: tb/tb_turn_sequencer.sv
// Table-driven, scoreboarded bench for turn_sequencer with a short hold and a two-hit win.
module tb_turn_sequencer;

  localparam int unsigned HC = 4;
  localparam int unsigned SC = 2;
  localparam int unsigned HW = 3;
  localparam int unsigned SW = 3;

  typedef struct packed {
    logic [5:0]    screen;
    logic          turn;
    logic          req;
    logic          board;
    logic [SW-1:0] p1;
    logic [SW-1:0] p2;
    logic          go;
  } exp_t;

  typedef struct packed {
    logic start;
    logic fire;
    logic ack;
    logic hit;
    exp_t exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_pulse, fire_pulse, lookup_ack, lookup_hit;
  logic          lookup_req, lookup_board, turn, game_over;
  logic [5:0]    screen;
  logic [SW-1:0] p1_score, p2_score;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];
  vec_t vecs[$];

  turn_sequencer #(
    .HOLD_CYCLES (HC),
    .SHIP_CELLS  (SC),
    .HOLD_W      (HW),
    .SCORE_W     (SW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_pulse  (start_pulse),
    .fire_pulse   (fire_pulse),
    .lookup_ack   (lookup_ack),
    .lookup_hit   (lookup_hit),
    .lookup_req   (lookup_req),
    .lookup_board (lookup_board),
    .turn         (turn),
    .screen       (screen),
    .p1_score     (p1_score),
    .p2_score     (p2_score),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input int scr, input int t, input int rq, input int brd,
                              input int s1, input int s2, input int g);
    exp_t e;
    e.screen = 6'(scr);
    e.turn   = 1'(t);
    e.req    = 1'(rq);
    e.board  = 1'(brd);
    e.p1     = SW'(s1);
    e.p2     = SW'(s2);
    e.go     = 1'(g);
    return e;
  endfunction

  task automatic add(input int s, input int f, input int a, input int h,
                     input int scr, input int t, input int rq, input int brd,
                     input int s1, input int s2, input int g);
    vec_t v;
    v.start = 1'(s);
    v.fire  = 1'(f);
    v.ack   = 1'(a);
    v.hit   = 1'(h);
    v.exp   = mk(scr, t, rq, brd, s1, s2, g);
    vecs.push_back(v);
  endtask

  // Pop the oldest expectation and compare it with the current DUT outputs
  task automatic check_pop(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb_q.pop_front();
    checks++;
    if (screen !== e.screen || turn !== e.turn || lookup_req !== e.req ||
        lookup_board !== e.board || p1_score !== e.p1 || p2_score !== e.p2 ||
        game_over !== e.go) begin
      errors++;
      $display("FAIL %s: got scr=%0d turn=%0d req=%0d brd=%0d p1=%0d p2=%0d go=%0d want scr=%0d turn=%0d req=%0d brd=%0d p1=%0d p2=%0d go=%0d",
               name, screen, turn, lookup_req, lookup_board, p1_score, p2_score, game_over,
               e.screen, e.turn, e.req, e.board, e.p1, e.p2, e.go);
    end
  endtask

  // Drive one cycle of inputs, record the expectation, then compare after the edge
  task automatic drive(input logic s, input logic f, input logic a, input logic h,
                       input exp_t e, input string name);
    start_pulse = s;
    fire_pulse  = f;
    lookup_ack  = a;
    lookup_hit  = h;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_pop(name);
  endtask

  // Assert reset mid-cycle and check the outputs drop immediately, then release cleanly
  task automatic async_reset(input string name);
    #2;
    rst_n = 1'b0;
    start_pulse = 1'b0;
    fire_pulse  = 1'b0;
    lookup_ack  = 1'b0;
    lookup_hit  = 1'b0;
    #1;
    sb_q.push_back(mk(1, 0, 0, 1, 0, 0, 0));
    check_pop(name);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    start_pulse = 1'b0;
    fire_pulse  = 1'b0;
    lookup_ack  = 1'b0;
    lookup_hit  = 1'b0;

    // Main game: P1 miss, P2 miss, P1 hit, P2 miss, P1 hit -> P1 wins, then restart
    add(0,1,0,0,  1,0,0,1,0,0,0);   // fire in idle ignored
    add(1,1,0,0, 32,0,0,1,0,0,0);   // start beats fire
    add(0,0,0,0, 32,0,0,1,0,0,0);
    add(0,1,0,0, 32,0,1,1,0,0,0);   // P1 fires at P2 board
    add(0,0,0,0, 32,0,1,1,0,0,0);   // waiting for ack
    add(0,0,1,0,  4,0,0,1,0,0,0);   // miss
    for (int i = 0; i < 3; i++) add(0,0,0,0, 4,0,0,1,0,0,0);
    add(0,0,0,0, 32,1,0,0,0,0,0);   // P2 turn
    add(0,1,0,0, 32,1,1,0,0,0,0);
    add(0,0,1,0,  4,1,0,0,0,0,0);
    for (int i = 0; i < 3; i++) add(0,0,0,0, 4,1,0,0,0,0,0);
    add(0,0,0,0, 32,0,0,1,0,0,0);
    add(0,1,0,0, 32,0,1,1,0,0,0);
    add(0,0,1,1,  2,0,0,1,1,0,0);   // ack in first req cycle, hit
    for (int i = 0; i < 3; i++) add(0,0,0,0, 2,0,0,1,1,0,0);
    add(0,0,0,0, 32,1,0,0,1,0,0);
    add(0,1,0,0, 32,1,1,0,1,0,0);
    add(0,0,1,0,  4,1,0,0,1,0,0);
    for (int i = 0; i < 3; i++) add(0,0,0,0, 4,1,0,0,1,0,0);
    add(0,0,0,0, 32,0,0,1,1,0,0);
    add(0,1,0,0, 32,0,1,1,1,0,0);
    add(0,1,0,0, 32,0,1,1,1,0,0);   // fire during lookup ignored
    add(0,0,1,1,  2,0,0,1,2,0,0);   // second hit
    add(0,1,0,0,  2,0,0,1,2,0,0);   // fire during hold ignored
    add(1,0,0,0,  2,0,0,1,2,0,0);   // start mid-game ignored
    add(0,0,0,0,  2,0,0,1,2,0,0);
    add(0,0,0,0,  8,0,0,1,2,0,1);   // P1 wins
    add(0,1,1,1,  8,0,0,1,2,0,1);   // fire and stray ack in win ignored
    add(0,0,0,0,  8,0,0,1,2,0,1);
    add(1,0,0,0, 32,0,0,1,0,0,0);   // restart
    add(0,0,1,1, 32,0,0,1,0,0,0);   // stray ack in aim ignored
    add(1,1,0,0, 32,0,1,1,0,0,0);   // start ignored, fire taken
    add(0,0,1,1,  2,0,0,1,1,0,0);
    add(0,0,0,0,  2,0,0,1,1,0,0);   // now inside the hold

    #12;
    sb_q.push_back(mk(1, 0, 0, 1, 0, 0, 0));
    check_pop("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].fire, vecs[i].ack, vecs[i].hit, vecs[i].exp,
            $sformatf("vec%0d", i));
    end

    async_reset("rst_mid_hold");
    drive(1'b1, 1'b0, 1'b0, 1'b0, mk(32, 0, 0, 1, 0, 0, 0), "post_rst_start");
    drive(1'b0, 1'b1, 1'b0, 1'b0, mk(32, 0, 1, 1, 0, 0, 0), "post_rst_fire");
    drive(1'b0, 1'b0, 1'b0, 1'b0, mk(32, 0, 1, 1, 0, 0, 0), "lookup_wait");

    async_reset("rst_mid_lookup");
    drive(1'b0, 1'b0, 1'b1, 1'b1, mk(1, 0, 0, 1, 0, 0, 0), "idle_stray_ack");
    drive(1'b1, 1'b0, 1'b0, 1'b0, mk(32, 0, 0, 1, 0, 0, 0), "rec_start");
    drive(1'b0, 1'b1, 1'b0, 1'b0, mk(32, 0, 1, 1, 0, 0, 0), "rec_fire");
    drive(1'b0, 1'b0, 1'b1, 1'b1, mk(2, 0, 0, 1, 1, 0, 0), "rec_hit");
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b0, 1'b0, 1'b0, mk(2, 0, 0, 1, 1, 0, 0), $sformatf("rec_hold%0d", i));
    drive(1'b0, 1'b0, 1'b0, 1'b0, mk(32, 1, 0, 0, 1, 0, 0), "rec_p2_turn");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
